// File: rtl/vend_pkg.sv
// vend_pkg: shared state type, default timeouts and pulse constants for the vending dispense path
package vend_pkg;
  typedef enum logic [2:0] {IDLE, PROD_RUN, PROD_CLR, CHG_RUN, CHG_CLR, FAULT} dispense_state_t;
  localparam int MOTOR_TMO_DEF = 1000;
  localparam int HOPPER_TMO_DEF = 500;
  localparam int PEND_W_DEF = 2;
  localparam int REQ_PULSE_CYCLES = 1;
  localparam int SENSE_SYNC_STAGES = 2;
endpackage

// File: rtl/vend_dispense_ctrl_if.sv
// vend_dispense_ctrl_if: request, sensor and actuator signals around the dispense controller
interface vend_dispense_ctrl_if
  import vend_pkg::*;
#(
  parameter int PW = PEND_W_DEF
);
  logic prod_req;
  logic change_req;
  logic prod_sense;
  logic coin_sense;
  logic fault_clr;
  logic motor_on;
  logic hopper_on;
  logic busy;
  logic fault;
  logic req_drop;
  logic [PW-1:0] prod_pend;
  logic [PW-1:0] chg_pend;
  modport master (
    output prod_req, change_req, prod_sense, coin_sense, fault_clr,
    input  motor_on, hopper_on, busy, fault, req_drop, prod_pend, chg_pend
  );
  modport slave (
    input  prod_req, change_req, prod_sense, coin_sense, fault_clr,
    output motor_on, hopper_on, busy, fault, req_drop, prod_pend, chg_pend
  );
endinterface

// File: rtl/vend_sync2.sv
// vend_sync2: two-flop synchronizer for an asynchronous level input
module vend_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  always_ff @(posedge clk) begin
    if (!rst_n) {q_o, meta_q} <= 2'b00;
    else {q_o, meta_q} <= {meta_q, d_i};
  end
endmodule

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: queues vend/change pulses and runs motor or hopper until its sensor confirms
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int MOTOR_TMO = MOTOR_TMO_DEF,
  parameter int HOPPER_TMO = HOPPER_TMO_DEF,
  parameter int PW = PEND_W_DEF
) (
  input logic clk,
  input logic rst_n,
  vend_dispense_ctrl_if.slave bus
);
  localparam int TMO_MAX = (MOTOR_TMO > HOPPER_TMO) ? MOTOR_TMO : HOPPER_TMO;
  localparam int TW = $clog2(TMO_MAX + 1);
  localparam logic [TW-1:0] M_LAST = TW'(MOTOR_TMO - 1);
  localparam logic [TW-1:0] H_LAST = TW'(HOPPER_TMO - 1);
  dispense_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] prod_pend_q, prod_pend_d, chg_pend_q, chg_pend_d;
  logic motor_q, hopper_q, busy_q, fault_q, drop_q;
  logic ps_s, cs_s, prod_dec, chg_dec, prod_full, chg_full;
  vend_sync2 u_ps (.clk, .rst_n, .d_i(bus.prod_sense), .q_o(ps_s));
  vend_sync2 u_cs (.clk, .rst_n, .d_i(bus.coin_sense), .q_o(cs_s));
  assign prod_full = &prod_pend_q;
  assign chg_full = &chg_pend_q;
  // a request at full scale is dropped even if a decrement lands in the same cycle
  assign prod_pend_d = prod_pend_q + PW'(bus.prod_req && !prod_full) - PW'(prod_dec);
  assign chg_pend_d = chg_pend_q + PW'(bus.change_req && !chg_full) - PW'(chg_dec);
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    prod_dec = 1'b0;
    chg_dec = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        state_d = (prod_pend_q != '0) ? PROD_RUN : (chg_pend_q != '0) ? CHG_RUN : IDLE;
      end
      PROD_RUN: begin
        prod_dec = ps_s;
        timer_d = ps_s ? '0 : timer_q + TW'(1);
        state_d = ps_s ? PROD_CLR : (timer_q == M_LAST) ? FAULT : PROD_RUN;
      end
      PROD_CLR: state_d = !ps_s ? IDLE : (timer_q == M_LAST) ? FAULT : PROD_CLR;
      CHG_RUN: begin
        chg_dec = cs_s;
        timer_d = cs_s ? '0 : timer_q + TW'(1);
        state_d = cs_s ? CHG_CLR : (timer_q == H_LAST) ? FAULT : CHG_RUN;
      end
      CHG_CLR: state_d = !cs_s ? IDLE : (timer_q == H_LAST) ? FAULT : CHG_CLR;
      FAULT: begin
        timer_d = '0;
        state_d = bus.fault_clr ? IDLE : FAULT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      prod_pend_q <= '0;
      chg_pend_q <= '0;
      motor_q <= 1'b0;
      hopper_q <= 1'b0;
      busy_q <= 1'b0;
      fault_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      prod_pend_q <= prod_pend_d;
      chg_pend_q <= chg_pend_d;
      motor_q <= state_d == PROD_RUN;
      hopper_q <= state_d == CHG_RUN;
      busy_q <= state_d != IDLE;
      fault_q <= state_d == FAULT;
      drop_q <= (bus.prod_req && prod_full) || (bus.change_req && chg_full);
    end
  end
  assign bus.motor_on = motor_q;
  assign bus.hopper_on = hopper_q;
  assign bus.busy = busy_q;
  assign bus.fault = fault_q;
  assign bus.req_drop = drop_q;
  assign bus.prod_pend = prod_pend_q;
  assign bus.chg_pend = chg_pend_q;
endmodule
